// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide controller: op codes, FSM states, constants.
// The accumulate state exists only when HILO_ACC_EN is defined.
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } hilo_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
`ifdef HILO_ACC_EN
    ST_ACC,
`endif
    ST_WR
  } hilo_state_e;

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  function automatic logic [31:0] abs_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// done is high during the final iteration; quotient/remainder are valid from the next cycle.
module div_radix2_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    // Top bit of the widened difference is the borrow: set means "restore".
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CW'(WIDTH);
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign done      = (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencing controller: runs MULT/DIV/MTHI/MTLO, stalls EX, issues registered HI/LO writes.
// Define HILO_ACC_EN to add MADD/MADDU/MSUB/MSUBU with an extra accumulate cycle.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned DIV_ITERS  = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_i,
  output logic [31:0] lo_i
);

  hilo_op_e    op_e;
  hilo_state_e state_q, state_d;

  logic        busy_q, busy_d;
  logic        hi_write_q, hi_write_d;
  logic        lo_write_q, lo_write_d;
  logic [31:0] hi_i_q, hi_i_d;
  logic [31:0] lo_i_q, lo_i_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        mul_signed_q, mul_signed_d;
  logic [1:0]  mul_cnt_q, mul_cnt_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;

`ifdef HILO_ACC_EN
  logic        acc_q, acc_d;
  logic        acc_sub_q, acc_sub_d;
  logic [63:0] acc_sum;
`else
  logic [63:0] unused_acc_cur;
  assign unused_acc_cur = {hi_cur, lo_cur};
`endif

  logic        accept;
  logic        mul_sgn_now;
  logic [31:0] mul_a, mul_b;
  logic [63:0] product;
  logic        div_signed;
  logic [31:0] div_a_mag, div_b_mag;
  logic        div_start, div_abort, div_done;
  logic [31:0] div_quo, div_rem;

  assign op_e   = hilo_op_e'(op);
  assign accept = op_valid && !flush && (state_q == ST_IDLE);

  // Operands come straight from EX for a single-cycle multiply, otherwise from the latches.
  always_comb begin
    mul_a       = (state_q == ST_IDLE) ? src_a : a_q;
    mul_b       = (state_q == ST_IDLE) ? src_b : b_q;
    mul_sgn_now = (state_q == ST_IDLE) ? (op_e == OP_MULT || op_e == OP_MADD || op_e == OP_MSUB)
                                       : mul_signed_q;
    product     = (mul_sgn_now ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a}) *
                  (mul_sgn_now ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b});
  end

`ifdef HILO_ACC_EN
  assign acc_sum = acc_sub_q ? ({hi_cur, lo_cur} - product) : ({hi_cur, lo_cur} + product);
`endif

  assign div_signed = (op_e == OP_DIV);
  assign div_a_mag  = abs_mag(src_a, div_signed);
  assign div_b_mag  = abs_mag(src_b, div_signed);
  assign div_abort  = flush && (state_q == ST_DIV);

  div_radix2_core #(
    .WIDTH (DIV_ITERS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (div_a_mag),
    .divisor   (div_b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d      = state_q;
    hi_write_d   = 1'b0;
    lo_write_d   = 1'b0;
    hi_i_d       = hi_i_q;
    lo_i_d       = lo_i_q;
    a_d          = a_q;
    b_d          = b_q;
    mul_signed_d = mul_signed_q;
    mul_cnt_d    = mul_cnt_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    div_start    = 1'b0;
`ifdef HILO_ACC_EN
    acc_d        = acc_q;
    acc_sub_d    = acc_sub_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_e)
            OP_MTHI: begin
              state_d    = ST_WR;
              hi_write_d = 1'b1;
              hi_i_d     = src_a;
            end
            OP_MTLO: begin
              state_d    = ST_WR;
              lo_write_d = 1'b1;
              lo_i_d     = src_a;
            end
            OP_MULT, OP_MULTU: begin
              a_d          = src_a;
              b_d          = src_b;
              mul_signed_d = (op_e == OP_MULT);
`ifdef HILO_ACC_EN
              acc_d        = 1'b0;
`endif
              if (MUL_STAGES > 1) begin
                state_d   = ST_MUL;
                mul_cnt_d = 2'(MUL_STAGES - 2);
              end else begin
                state_d    = ST_WR;
                hi_write_d = 1'b1;
                lo_write_d = 1'b1;
                {hi_i_d, lo_i_d} = product;
              end
            end
`ifdef HILO_ACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              a_d          = src_a;
              b_d          = src_b;
              mul_signed_d = (op_e == OP_MADD || op_e == OP_MSUB);
              acc_d        = 1'b1;
              acc_sub_d    = (op_e == OP_MSUB || op_e == OP_MSUBU);
              if (MUL_STAGES > 1) begin
                state_d   = ST_MUL;
                mul_cnt_d = 2'(MUL_STAGES - 2);
              end else begin
                state_d = ST_ACC;
              end
            end
`endif
            OP_DIV, OP_DIVU: begin
              if (src_b == '0) begin
                state_d    = ST_WR;
                hi_write_d = 1'b1;
                lo_write_d = 1'b1;
                hi_i_d     = src_a;
                lo_i_d     = DIV_ZERO_LO;
              end else begin
                state_d   = ST_DIV;
                div_start = 1'b1;
                q_neg_d   = div_signed && (src_a[31] ^ src_b[31]);
                r_neg_d   = div_signed && src_a[31];
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mul_cnt_q == '0) begin
`ifdef HILO_ACC_EN
          if (acc_q) begin
            state_d = ST_ACC;
          end else begin
            state_d    = ST_WR;
            hi_write_d = 1'b1;
            lo_write_d = 1'b1;
            {hi_i_d, lo_i_d} = product;
          end
`else
          state_d    = ST_WR;
          hi_write_d = 1'b1;
          lo_write_d = 1'b1;
          {hi_i_d, lo_i_d} = product;
`endif
        end else begin
          mul_cnt_d = mul_cnt_q - 2'd1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_WR;
          hi_write_d = 1'b1;
          lo_write_d = 1'b1;
          lo_i_d     = q_neg_q ? (~div_quo + 32'd1) : div_quo;
          hi_i_d     = r_neg_q ? (~div_rem + 32'd1) : div_rem;
        end
      end
`ifdef HILO_ACC_EN
      ST_ACC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_WR;
          hi_write_d = 1'b1;
          lo_write_d = 1'b1;
          {hi_i_d, lo_i_d} = acc_sum;
        end
      end
`endif
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      hi_write_q   <= 1'b0;
      lo_write_q   <= 1'b0;
      hi_i_q       <= '0;
      lo_i_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      mul_cnt_q    <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
`ifdef HILO_ACC_EN
      acc_q        <= 1'b0;
      acc_sub_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      hi_write_q   <= hi_write_d;
      lo_write_q   <= lo_write_d;
      hi_i_q       <= hi_i_d;
      lo_i_q       <= lo_i_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mul_signed_q <= mul_signed_d;
      mul_cnt_q    <= mul_cnt_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
`ifdef HILO_ACC_EN
      acc_q        <= acc_d;
      acc_sub_q    <= acc_sub_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign hi_write = hi_write_q;
  assign lo_write = lo_write_q;
  assign hi_i     = hi_i_q;
  assign lo_i     = lo_i_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus random ops against an arithmetic model.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam int unsigned MUL_STAGES = 2;
  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        rst, op_valid, flush;
  logic [3:0]  op;
  logic [31:0] src_a, src_b, hi_cur, lo_cur;
  logic        busy, hi_write, lo_write;
  logic [31:0] hi_i, lo_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          lat;
    int          busy;
    logic        hw;
    logic        lw;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  typedef struct {
    int          lat;
    int          busy_cnt;
    int          busy_first;
    int          busy_last;
    logic        hw;
    logic        lw;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          extra;
  } obs_t;

  hilo_muldiv_ctrl #(
    .DIV_ITERS  (32),
    .MUL_STAGES (MUL_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .hi_cur   (hi_cur),
    .lo_cur   (lo_cur),
    .busy     (busy),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_i     (hi_i),
    .lo_i     (lo_i)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod64(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint p;
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'({32'd0, a}) * longint'({32'd0, b});
    return 64'(p);
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] hc, input logic [31:0] lc);
    exp_t e;
    longint n, d;
    logic [63:0] p;
    e = '{default: 0};
    case (hilo_op_e'(o))
      OP_MTHI: begin e.lat = 1; e.hw = 1'b1; e.hi = a; end
      OP_MTLO: begin e.lat = 1; e.lw = 1'b1; e.lo = a; end
      OP_MULT, OP_MULTU: begin
        p = prod64(a, b, o == OP_MULT);
        e.lat = MUL_STAGES; e.busy = MUL_STAGES - 1;
        e.hw = 1'b1; e.lw = 1'b1; e.hi = p[63:32]; e.lo = p[31:0];
      end
      OP_DIV, OP_DIVU: begin
        e.hw = 1'b1; e.lw = 1'b1;
        if (b == 32'd0) begin
          e.lat = 1; e.hi = a; e.lo = 32'hFFFF_FFFF;
        end else begin
          e.lat = 34; e.busy = 33;
          if (o == OP_DIV) begin
            n = longint'($signed(a)); d = longint'($signed(b));
            e.lo = 32'(n / d); e.hi = 32'(n % d);
          end else begin
            e.lo = a / b; e.hi = a % b;
          end
        end
      end
`ifdef HILO_ACC_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        p = prod64(a, b, o == OP_MADD || o == OP_MSUB);
        if (o == OP_MSUB || o == OP_MSUBU) p = {hc, lc} - p;
        else                               p = {hc, lc} + p;
        e.lat = MUL_STAGES + 1; e.busy = MUL_STAGES;
        e.hw = 1'b1; e.lw = 1'b1; e.hi = p[63:32]; e.lo = p[31:0];
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Presents one op at the current negedge and records what the DUT does over the next cycles.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hc, input logic [31:0] lc, input bit hold,
                        input int flush_at, input int budget, output obs_t ob);
    ob = '{default: 0};
    op = o; src_a = a; src_b = b; hi_cur = hc; lo_cur = lc;
    op_valid = 1'b1;
    flush = (flush_at == 0);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (busy) begin
        ob.busy_cnt++;
        if (ob.busy_first == 0) ob.busy_first = k;
        ob.busy_last = k;
      end
      if (ob.lat == 0 && (hi_write || lo_write)) begin
        ob.lat = k; ob.hw = hi_write; ob.lw = lo_write; ob.hi = hi_i; ob.lo = lo_i;
      end else if (ob.lat != 0 && (hi_write || lo_write)) begin
        ob.extra = 1'b1;
      end
      if (!hold || ob.lat != 0) op_valid = 1'b0;
      flush = (k == flush_at);
      if (ob.lat != 0 && k == ob.lat + 1) break;
    end
    op_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op = '0;
    src_a = '0; src_b = '0; hi_cur = '0; lo_cur = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({hi_write, lo_write} !== 2'b00) begin failures++; $display("FAIL reset_writes got %b want 00", {hi_write, lo_write}); end
    checks++; if ({hi_i, lo_i} !== 64'd0) begin failures++; $display("FAIL reset_data got %h_%h want 0_0", hi_i, lo_i); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mtlo();
    obs_t ob;
    run_op(OP_MTLO, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob);
    checks++; if (ob.lat !== 1) begin failures++; $display("FAIL mtlo_latency got %0d want 1", ob.lat); end
    checks++; if ({ob.hw, ob.lw, ob.lo} !== {1'b0, 1'b1, 32'h1234_5678})
      begin failures++; $display("FAIL mtlo_write got hw=%b lw=%b lo=%h want hw=0 lw=1 lo=12345678", ob.hw, ob.lw, ob.lo); end
    checks++; if (ob.busy_cnt !== 0) begin failures++; $display("FAIL mtlo_busy got %0d busy cycles want 0", ob.busy_cnt); end
  endtask

  task automatic test_mult();
    obs_t ob;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 1'b1, -1, BUDGET, ob);
    checks++; if ({ob.lat, ob.busy_cnt} !== {32'(MUL_STAGES), 32'(MUL_STAGES - 1)})
      begin failures++; $display("FAIL mult_timing got lat=%0d busy=%0d want %0d %0d", ob.lat, ob.busy_cnt, MUL_STAGES, MUL_STAGES - 1); end
    checks++; if ({ob.hw, ob.lw, ob.hi, ob.lo} !== {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA})
      begin failures++; $display("FAIL mult_signed got %b%b %h_%h want 11 ffffffff_fffffffa", ob.hw, ob.lw, ob.hi, ob.lo); end
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob);
    checks++; if ({ob.hw, ob.lw, ob.hi, ob.lo} !== {2'b11, 32'h0000_0002, 32'hFFFF_FFFA})
      begin failures++; $display("FAIL multu got %b%b %h_%h want 11 00000002_fffffffa", ob.hw, ob.lw, ob.hi, ob.lo); end
  endtask

  task automatic test_div();
    obs_t ob;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b1, -1, BUDGET, ob);
    checks++; if ({ob.lat, ob.busy_first, ob.busy_last, ob.busy_cnt} !== {32'd34, 32'd1, 32'd33, 32'd33})
      begin failures++; $display("FAIL div_timing got lat=%0d busy=%0d..%0d (%0d) want 34 1..33 (33)", ob.lat, ob.busy_first, ob.busy_last, ob.busy_cnt); end
    checks++; if ({ob.hi, ob.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
      begin failures++; $display("FAIL div_signed got hi=%h lo=%h want ffffffff fffffffd", ob.hi, ob.lo); end
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob);
    checks++; if ({ob.hi, ob.lo} !== {32'd2, 32'd14})
      begin failures++; $display("FAIL divu got hi=%h lo=%h want 2 e", ob.hi, ob.lo); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob);
    checks++; if ({ob.hi, ob.lo} !== {32'h0, 32'h8000_0000})
      begin failures++; $display("FAIL div_overflow got hi=%h lo=%h want 0 80000000", ob.hi, ob.lo); end
  endtask

  task automatic test_div_zero();
    obs_t ob;
    run_op(OP_DIVU, 32'h55, 32'h0, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob);
    checks++; if ({ob.lat, ob.busy_cnt} !== {32'd1, 32'd0})
      begin failures++; $display("FAIL divzero_timing got lat=%0d busy=%0d want 1 0", ob.lat, ob.busy_cnt); end
    checks++; if ({ob.hi, ob.lo} !== {32'h55, 32'hFFFF_FFFF})
      begin failures++; $display("FAIL divzero_data got hi=%h lo=%h want 55 ffffffff", ob.hi, ob.lo); end
  endtask

  task automatic test_flush();
    obs_t ob;
    run_op(OP_DIV, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0, 10, 11, ob);
    checks++; if ({ob.lat, ob.busy_last, ob.busy_cnt} !== {32'd0, 32'd10, 32'd10})
      begin failures++; $display("FAIL flush_div got lat=%0d busy_last=%0d busy=%0d want 0 10 10", ob.lat, ob.busy_last, ob.busy_cnt); end
    run_op(OP_MTHI, 32'hCAFE_0001, 32'h0, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob);
    checks++; if ({ob.lat, ob.hw, ob.lw, ob.hi} !== {32'd1, 2'b10, 32'hCAFE_0001})
      begin failures++; $display("FAIL flush_then_mthi got lat=%0d %b%b hi=%h want 1 10 cafe0001", ob.lat, ob.hw, ob.lw, ob.hi); end
    run_op(OP_MTLO, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 1'b0, 0, 6, ob);
    checks++; if ({ob.lat, ob.busy_cnt} !== {32'd0, 32'd0})
      begin failures++; $display("FAIL flush_at_accept got lat=%0d busy=%0d want 0 0", ob.lat, ob.busy_cnt); end
  endtask

  task automatic test_back_to_back();
    obs_t ob1, ob2;
    run_op(OP_MTHI, 32'hAAAA_0000, 32'h0, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob1);
    run_op(OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob2);
    checks++; if ({ob1.lat, ob1.extra, ob1.hi} !== {32'd1, 1'b0, 32'hAAAA_0000})
      begin failures++; $display("FAIL b2b_first got lat=%0d extra=%b hi=%h want 1 0 aaaa0000", ob1.lat, ob1.extra, ob1.hi); end
    checks++; if ({ob2.lat, ob2.hi, ob2.lo} !== {32'(MUL_STAGES), 32'd0, 32'd42})
      begin failures++; $display("FAIL b2b_second got lat=%0d hi=%h lo=%h want %0d 0 2a", ob2.lat, ob2.hi, ob2.lo, MUL_STAGES); end
  endtask

  task automatic test_acc();
    obs_t ob;
    run_op(OP_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, -1, BUDGET, ob);
`ifdef HILO_ACC_EN
    checks++; if ({ob.lat, ob.busy_cnt, ob.hi, ob.lo} !== {32'(MUL_STAGES + 1), 32'(MUL_STAGES), 32'd1, 32'd0})
      begin failures++; $display("FAIL maddu got lat=%0d busy=%0d hi=%h lo=%h want %0d %0d 1 0", ob.lat, ob.busy_cnt, ob.hi, ob.lo, MUL_STAGES + 1, MUL_STAGES); end
`else
    checks++; if ({ob.lat, ob.busy_cnt} !== {32'd0, 32'd0})
      begin failures++; $display("FAIL maddu_noop got lat=%0d busy=%0d want 0 0", ob.lat, ob.busy_cnt); end
`endif
  endtask

  task automatic test_reset_midop();
    obs_t ob;
    int writes;
    op = OP_DIVU; src_a = 32'd12345; src_b = 32'd11; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, hi_write, lo_write, hi_i, lo_i} !== 67'd0)
      begin failures++; $display("FAIL reset_midop got busy=%b w=%b%b hi=%h lo=%h want all 0", busy, hi_write, lo_write, hi_i, lo_i); end
    rst = 1'b0;
    writes = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hi_write || lo_write || busy) writes++;
    end
    checks++; if (writes !== 0) begin failures++; $display("FAIL reset_midop_quiet got %0d active cycles want 0", writes); end
    run_op(OP_MTLO, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0, 1'b0, -1, BUDGET, ob);
    checks++; if ({ob.lat, ob.lo} !== {32'd1, 32'h0BAD_F00D})
      begin failures++; $display("FAIL reset_then_mtlo got lat=%0d lo=%h want 1 0badf00d", ob.lat, ob.lo); end
  endtask

  task automatic test_random();
    obs_t ob;
    exp_t e;
    logic [3:0]  o;
    logic [31:0] a, b, hc, lc;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) o = 4'($urandom_range(1, 4));
      a = $urandom; b = $urandom; hc = $urandom; lc = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'($signed(-$urandom_range(1, 9)));
        default: ;
      endcase
      e = model(o, a, b, hc, lc);
      run_op(o, a, b, hc, lc, bit'($urandom_range(0, 1)), -1, BUDGET, ob);
      checks++; if (ob.lat !== e.lat)
        begin failures++; $display("FAIL rand%0d_latency op=%0d got %0d want %0d", i, o, ob.lat, e.lat); end
      checks++; if ({ob.busy_cnt, ob.busy_last, ob.busy_first} !== {e.busy, e.busy, (e.busy > 0) ? 32'd1 : 32'd0})
        begin failures++; $display("FAIL rand%0d_busy op=%0d got cnt=%0d %0d..%0d want %0d", i, o, ob.busy_cnt, ob.busy_first, ob.busy_last, e.busy); end
      checks++; if ({ob.hw, ob.lw, ob.extra} !== {e.hw, e.lw, 1'b0})
        begin failures++; $display("FAIL rand%0d_wen op=%0d got %b%b extra=%b want %b%b 0", i, o, ob.hw, ob.lw, ob.extra, e.hw, e.lw); end
      if (e.hw) begin
        checks++; if (ob.hi !== e.hi)
          begin failures++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, a, b, ob.hi, e.hi); end
      end
      if (e.lw) begin
        checks++; if (ob.lo !== e.lo)
          begin failures++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, a, b, ob.lo, e.lo); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mtlo();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_acc();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
